// File: rtl/convert_sched_if.sv
// Handshake bundle between convert_sched and its producers/consumer.
// dout_ovf is only present when CONVERT_SCHED_OVF_EN is defined.
interface convert_sched_if #(
    parameter int N_CHANS    = 4,
    parameter int CHAN_W     = 2,
    parameter int N_BITS_IN  = 4,
    parameter int N_BITS_OUT = 4
);
    logic [N_CHANS*N_BITS_IN-1:0] din;
    logic [N_CHANS-1:0]           din_valid;
    logic [N_CHANS-1:0]           din_ready;
    logic [N_BITS_OUT-1:0]        dout;
    logic [CHAN_W-1:0]            dout_chan;
    logic                         dout_valid;
    logic                         dout_ready;
`ifdef CONVERT_SCHED_OVF_EN
    logic                         dout_ovf;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_chan, dout_valid, dout_ovf
    );
    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_chan, dout_valid, dout_ovf
    );
`else
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_chan, dout_valid
    );
    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_chan, dout_valid
    );
`endif
endinterface

// File: rtl/convert_sched.sv
// Round-robin scheduler sharing one fixed-point converter between N_CHANS channels.
// Define CONVERT_SCHED_OVF_EN to add the registered dout_ovf overflow flag.
module convert #(
    parameter int N_BITS_IN  = 4,
    parameter int BIN_PT_IN  = 4,
    parameter int N_BITS_OUT = 4,
    parameter int BIN_PT_OUT = 2
) (
    input  logic [N_BITS_IN-1:0]  din,
`ifdef CONVERT_SCHED_OVF_EN
    output logic                  ovf,
`endif
    output logic [N_BITS_OUT-1:0] dout
);
    localparam int LSH = (BIN_PT_OUT > BIN_PT_IN) ? (BIN_PT_OUT - BIN_PT_IN) : 0;
    localparam int RSH = (BIN_PT_IN > BIN_PT_OUT) ? (BIN_PT_IN - BIN_PT_OUT) : 0;
    localparam int EW  = N_BITS_IN + LSH + N_BITS_OUT;

    // Left shift zero-pads, right shift floors; the cast wraps above the output MSB.
    assign dout = N_BITS_OUT'((EW'(din) << LSH) >> RSH);
`ifdef CONVERT_SCHED_OVF_EN
    assign ovf  = ((((EW'(din) << LSH) >> RSH) >> N_BITS_OUT) != {EW{1'b0}});
`endif
endmodule

module convert_sched #(
    parameter int N_CHANS    = 4,
    parameter int CHAN_W     = 2,
    parameter int N_BITS_IN  = 4,
    parameter int BIN_PT_IN  = 4,
    parameter int N_BITS_OUT = 4,
    parameter int BIN_PT_OUT = 2
) (
    input logic            clk,
    input logic            rst_n,
    convert_sched_if.slave bus
);
    typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                state_r, state_nxt_s;
    logic [CHAN_W-1:0]     rr_ptr_r, grant_s, idx_s;
    logic                  any_valid_s, can_load_s, accept_s;
    logic [N_CHANS-1:0]    din_ready_s;
    logic [N_BITS_IN-1:0]  sample_s;
    logic [N_BITS_OUT-1:0] conv_s, dout_r;
    logic [CHAN_W-1:0]     chan_r;
`ifdef CONVERT_SCHED_OVF_EN
    logic                  ovf_s, ovf_r;
`endif

    // Round-robin search for the first valid channel starting at rr_ptr_r.
    always_comb begin
        grant_s     = rr_ptr_r;
        any_valid_s = 1'b0;
        idx_s       = rr_ptr_r;
        for (int i = 0; i < N_CHANS; i++) begin
            idx_s = CHAN_W'((int'(rr_ptr_r) + i) % N_CHANS);
            if (!any_valid_s && bus.din_valid[idx_s]) begin
                grant_s     = idx_s;
                any_valid_s = 1'b1;
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    assign can_load_s = (state_r == EMPTY) | bus.dout_ready;

    // One-hot ready to the granted channel; forced low while reset is asserted.
    always_comb begin
        din_ready_s = {N_CHANS{1'b0}};
        for (int k = 0; k < N_CHANS; k++) begin
            din_ready_s[k] = rst_n & can_load_s & any_valid_s
                           & (grant_s == CHAN_W'(k)) & bus.din_valid[k];
        end
    end

    assign accept_s = |din_ready_s;
    assign sample_s = bus.din[int'(grant_s)*N_BITS_IN +: N_BITS_IN];

    convert #(
        .N_BITS_IN  (N_BITS_IN),
        .BIN_PT_IN  (BIN_PT_IN),
        .N_BITS_OUT (N_BITS_OUT),
        .BIN_PT_OUT (BIN_PT_OUT)
    ) u_convert (
        .din  (sample_s),
`ifdef CONVERT_SCHED_OVF_EN
        .ovf  (ovf_s),
`endif
        .dout (conv_s)
    );

    // Output stage next state: a new accept always refills, otherwise drain on dout_ready.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) state_nxt_s = FULL;
                else          state_nxt_s = EMPTY;
            end
            FULL: begin
                if (accept_s)            state_nxt_s = FULL;
                else if (bus.dout_ready) state_nxt_s = EMPTY;
                else                     state_nxt_s = FULL;
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // State, round-robin pointer and output data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= EMPTY;
            rr_ptr_r <= {CHAN_W{1'b0}};
            dout_r   <= {N_BITS_OUT{1'b0}};
            chan_r   <= {CHAN_W{1'b0}};
`ifdef CONVERT_SCHED_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                rr_ptr_r <= (grant_s == CHAN_W'(N_CHANS - 1)) ? {CHAN_W{1'b0}}
                                                             : grant_s + CHAN_W'(1);
                dout_r   <= conv_s;
                chan_r   <= grant_s;
`ifdef CONVERT_SCHED_OVF_EN
                ovf_r    <= ovf_s;
`endif
            end
        end
    end

    assign bus.din_ready  = din_ready_s;
    assign bus.dout       = dout_r;
    assign bus.dout_chan  = chan_r;
    assign bus.dout_valid = (state_r == FULL);
`ifdef CONVERT_SCHED_OVF_EN
    assign bus.dout_ovf   = ovf_r;
`endif
endmodule

// File: tb/tb_convert_sched.sv
// Scoreboard bench for convert_sched: directed stimulus pushes hand-computed outputs,
// a negedge monitor pops and compares every transferred output.
module tb_convert_sched;
    localparam int N_CHANS = 4, CHAN_W = 2, N_BITS_IN = 4, BIN_PT_IN = 4;
    localparam int N_BITS_OUT = 4, BIN_PT_OUT = 2;

    typedef struct packed {
        logic [CHAN_W-1:0]     chan;
        logic [N_BITS_OUT-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [N_BITS_OUT-1:0] rr_exp [4] = '{4'b0011, 4'b0010, 4'b0001, 4'b0011};
    logic [N_CHANS-1:0]    oh;

    always #5 clk = ~clk;

    convert_sched_if #(.N_CHANS(N_CHANS), .CHAN_W(CHAN_W), .N_BITS_IN(N_BITS_IN),
                       .N_BITS_OUT(N_BITS_OUT)) bus ();
    convert_sched #(.N_CHANS(N_CHANS), .CHAN_W(CHAN_W), .N_BITS_IN(N_BITS_IN),
                    .BIN_PT_IN(BIN_PT_IN), .N_BITS_OUT(N_BITS_OUT), .BIN_PT_OUT(BIN_PT_OUT))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

`ifdef CONVERT_SCHED_OVF_EN
    convert_sched_if #(.N_CHANS(2), .CHAN_W(1), .N_BITS_IN(4), .N_BITS_OUT(2)) bus2 ();
    convert_sched #(.N_CHANS(2), .CHAN_W(1), .N_BITS_IN(4), .BIN_PT_IN(2),
                    .N_BITS_OUT(2), .BIN_PT_OUT(1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int ch, input logic [N_BITS_IN-1:0] v);
        bus.din[ch*N_BITS_IN +: N_BITS_IN] = v;
    endtask

    task automatic push_exp(input int ch, input logic [N_BITS_OUT-1:0] d);
        exp_t t;
        t.chan = CHAN_W'(ch);
        t.data = d;
        exp_q.push_back(t);
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got chan %0d data 0x%0h, expected no output",
                         bus.dout_chan, bus.dout);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_chan", 32'(bus.dout_chan), 32'(mon_e.chan));
                check("out_data", 32'(bus.dout), 32'(mon_e.data));
`ifdef CONVERT_SCHED_OVF_EN
                check("out_ovf", 32'(bus.dout_ovf), 32'd0);
`endif
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.din        = {(N_CHANS*N_BITS_IN){1'b0}};
        bus.din_valid  = 4'b1111;
        bus.dout_ready = 1'b1;
`ifdef CONVERT_SCHED_OVF_EN
        bus2.din        = 8'h00;
        bus2.din_valid  = 2'b00;
        bus2.dout_ready = 1'b1;
`endif
        #2;
        check("rst_din_ready", 32'(bus.din_ready), 32'd0);
        check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_dout_chan", 32'(bus.dout_chan), 32'd0);
        bus.din_valid = 4'b0000;
        repeat (2) step();
        rst_n = 1'b1;

`ifdef CONVERT_SCHED_OVF_EN
        bus2.din = {4'b0000, 4'b1000};
        bus2.din_valid = 2'b01;
        step();
        bus2.din_valid = 2'b00;
        @(negedge clk);
        check("ovf_2p0_dout", 32'(bus2.dout), 32'b00);
        check("ovf_2p0_flag", 32'(bus2.dout_ovf), 32'd1);
        bus2.din = {4'b0000, 4'b0010};
        bus2.din_valid = 2'b01;
        step();
        bus2.din_valid = 2'b00;
        @(negedge clk);
        check("ovf_0p5_dout", 32'(bus2.dout), 32'b01);
        check("ovf_0p5_flag", 32'(bus2.dout_ovf), 32'd0);
        step();
`endif

        // Single-channel conversions, including truncation cases.
        set_din(0, 4'b0100);
        bus.din_valid = 4'b0001;
        @(negedge clk);
        check("t1_din_ready", 32'(bus.din_ready), 32'b0001);
        push_exp(0, 4'b0001);
        step();
        set_din(2, 4'b0010);
        bus.din_valid = 4'b0100;
        @(negedge clk);
        check("t2_din_ready", 32'(bus.din_ready), 32'b0100);
        push_exp(2, 4'b0000);
        step();
        set_din(1, 4'b0001);
        bus.din_valid = 4'b0010;
        @(negedge clk);
        check("t3_din_ready", 32'(bus.din_ready), 32'b0010);
        push_exp(1, 4'b0000);
        step();
        set_din(3, 4'b1100);
        bus.din_valid = 4'b1000;
        @(negedge clk);
        check("t4_din_ready", 32'(bus.din_ready), 32'b1000);
        push_exp(3, 4'b0011);
        step();

        // All channels valid: rr pointer is back at 0, expect 0,1,2,3,0,1.
        set_din(0, 4'b1111);
        set_din(1, 4'b1000);
        set_din(2, 4'b0111);
        bus.din_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            oh = 4'b0001 << (i % 4);
            check("rr_din_ready", 32'(bus.din_ready), 32'(oh));
            push_exp(i % 4, rr_exp[i % 4]);
            step();
        end

        // Backpressure: stage holds ch1's sample, no new grant.
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_din_ready", 32'(bus.din_ready), 32'd0);
            check("bp_dout_valid", 32'(bus.dout_valid), 32'd1);
            check("bp_dout_chan", 32'(bus.dout_chan), 32'd1);
            check("bp_dout", 32'(bus.dout), 32'b0010);
        end
        step();
        bus.dout_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(bus.din_ready), 32'b0100);
        push_exp(2, 4'b0001);
        step();
        bus.din_valid = 4'b0000;
        step();

        // Reset while full and ch3 waiting for its grant.
        bus.din_valid  = 4'b0100;
        bus.dout_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_ready", 32'(bus.din_ready), 32'b0100);
        step();
        bus.din_valid = 4'b1000;
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.dout_valid), 32'd1);
        check("pre_rst_chan", 32'(bus.dout_chan), 32'd2);
        check("pre_rst_hold", 32'(bus.din_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.dout_valid), 32'd0);
        check("async_rst_dout", 32'(bus.dout), 32'd0);
        check("async_rst_chan", 32'(bus.dout_chan), 32'd0);
        check("async_rst_ready", 32'(bus.din_ready), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        bus.din_valid  = 4'b1010;
        bus.dout_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.din_ready), 32'b0010);
        push_exp(1, 4'b0010);
        step();
        bus.din_valid = 4'b0000;
        repeat (3) step();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/convert_sched.md
Name: convert_sched

Overview:
- Round-robin scheduler that shares one fixed-point format converter (`convert` instance) between N_CHANS requesting channels.
- Each channel presents a sample with a valid/ready handshake.
- The granted sample is converted and registered into a single output stage, tagged with its source channel.
- Sits between per-channel sample producers and a downstream consumer that expects a common output format.

Parameters:
- N_CHANS, 4, number of requesting channels (>=2).
- CHAN_W, 2, width of channel tag; must satisfy 2^CHAN_W >= N_CHANS.
- N_BITS_IN, 4, input sample width, unsigned.
- BIN_PT_IN, 4, input binary point (fractional bits).
- N_BITS_OUT, 4, output sample width, unsigned.
- BIN_PT_OUT, 2, output binary point (fractional bits).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  N_CHANS*N_BITS_IN  packed samples; channel k at bits [k*N_BITS_IN +: N_BITS_IN].
- din_valid  in  N_CHANS  per-channel sample valid.
- din_ready  out  N_CHANS  per-channel accept; at most one bit high.
- dout  out  N_BITS_OUT  converted sample.
- dout_chan  out  CHAN_W  channel index of dout.
- dout_valid  out  1  output stage holds a sample.
- dout_ready  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync release): dout=0, dout_chan=0, dout_valid=0, rr_ptr=0.
  - din_ready=0 while rst_n low.
  - Reset mid-transfer drops the held sample; no partial output.
- Output stage FSM, two states:
  - EMPTY (dout_valid=0) -> FULL on accept.
  - FULL -> EMPTY when dout_ready=1 and no new accept.
  - FULL -> FULL when dout_ready=1 and a new accept occurs in the same cycle.
  - FULL with dout_ready=0: dout, dout_chan and dout_valid are held stable.
- can_load = ~dout_valid | dout_ready (combinational).
- Arbitration:
  - grant = first channel k with din_valid[k]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_CHANS.
  - din_ready[k] = can_load & (k==grant) & din_valid[k].
  - din_ready is 0 for all channels when no channel is valid.
- Accept: when din_valid[g] & din_ready[g], on the next edge:
  - dout <= convert(din[g]); dout_chan <= g; dout_valid <= 1; rr_ptr <= (g+1) mod N_CHANS.
  - rr_ptr is unchanged when there is no accept.
- Latency: 1 cycle from accept to dout_valid. Throughput: 1 sample/cycle when dout_ready=1.
- Conversion: combinational `convert` instance on the muxed sample.
  - Align binary points.
  - Fractional bits below 2^-BIN_PT_OUT are truncated (floor, no rounding).
  - Bits above the output MSB are discarded (wrap).
  - Missing bits are zero-padded.
- Fairness: a continuously valid channel is granted at least once every N_CHANS accepts.
- din is sampled only in the accept cycle; it may change at any other time.
- din_valid may deassert without a handshake; the arbiter re-evaluates every cycle.

Optional Feature:
- Macro: CONVERT_SCHED_OVF_EN.
- Defined:
  - Adds output port dout_ovf (1 bit), registered alongside dout, reset 0, held under backpressure.
  - dout_ovf=1 when any discarded input bit above the output MSB was 1.
- Undefined:
  - Port absent, no overflow logic.
  - All other behaviour is identical.

Test Plan:
- Defaults; ch0 din=4'b0100 (0.25) valid, others idle, dout_ready=1 -> din_ready=4'b0001; next cycle dout=4'b0001, dout_chan=0, dout_valid=1.
- ch2 din=4'b0010 (0.125) -> dout=4'b0000, dout_chan=2 (truncation). ch1 din=4'b0001 -> dout=4'b0000.
- All four channels valid continuously, dout_ready=1 -> dout_chan sequence 0,1,2,3,0,1 on consecutive cycles, one accept per cycle.
- Output FULL and dout_ready=0 for 3 cycles -> din_ready=0, dout/dout_chan stable. Then dout_ready=1 -> the next channel after the held one is accepted in the same cycle, no sample lost or duplicated.
- rst_n pulsed low while dout_valid=1 and ch3 granted -> dout_valid=0 immediately (asynchronous). After release, first grant goes to the lowest valid channel from rr_ptr=0.
- CONVERT_SCHED_OVF_EN defined, N_BITS_IN=4, BIN_PT_IN=2, N_BITS_OUT=2, BIN_PT_OUT=1; din=4'b1000 (2.0) -> dout=2'b00, dout_ovf=1. din=4'b0010 (0.5) -> dout=2'b01, dout_ovf=0.
